// File: rtl/machine_tb_pkg.sv
// Purpose: shared types and defaults for the machine_output_checker slice.
// Contents: FSM state encoding, default golden sequence, default widths.
package machine_tb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned NUM_SAMPLES_DEFAULT = 8;
    localparam int unsigned CNT_W_DEFAULT       = 8;
    localparam logic [7:0]  EXPECTED_DEFAULT    = 8'b1011_0010;

endpackage

// File: rtl/machine_watchdog.sv
// Purpose: idle-cycle watchdog; counts enabled cycles since the last clear.
// Ports:
//   clk_i       - system clock
//   rst_i       - synchronous active-high reset
//   clear_i     - returns the count to zero (has priority over en_i)
//   en_i        - advances the count by one per cycle
//   expired_c_o - combinational: count has reached TIMEOUT_CYCLES-1
module machine_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 100
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_c_o
);

    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] count_q;

    assign expired_c_o = (count_q == WD_W'(TIMEOUT_CYCLES - 1));

    // Count stops at the expiry value so it can never wrap back to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (en_i && !expired_c_o) begin
            count_q <= count_q + WD_W'(1);
        end
    end

endmodule

// File: rtl/machine_output_checker.sv
// Purpose: compares the 1-bit result stream against a golden sequence,
//          counts mismatches and reports done/pass/timeout.
// Ports:
//   clk, rst         - clock, synchronous active-high reset
//   start            - pulse that (re)starts a check run
//   result_valid     - qualifies result
//   result           - sample under check
//   done             - run finished; held until start or rst
//   pass             - done and no errors and no timeout (combinational)
//   timeout          - run ended by the watchdog
//   error_count      - saturating mismatch count
//   sample_index     - samples consumed this run
//   first_err_index  - index of first mismatch, all-ones if none
module machine_output_checker
    import machine_tb_pkg::*;
#(
    parameter int unsigned            NUM_SAMPLES    = NUM_SAMPLES_DEFAULT,
    parameter logic [NUM_SAMPLES-1:0] EXPECTED       = NUM_SAMPLES'(EXPECTED_DEFAULT),
    parameter int unsigned            TIMEOUT_CYCLES = 100,
    parameter int unsigned            CNT_W          = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             result_valid,
    input  logic             result,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [CNT_W-1:0] error_count,
    output logic [CNT_W-1:0] sample_index,
    output logic [CNT_W-1:0] first_err_index
);

    state_e           state_q;
    logic [CNT_W-1:0] sample_index_q;
    logic [CNT_W-1:0] error_count_q;
    logic [CNT_W-1:0] first_err_q;
    logic             done_q;
    logic             timeout_q;

    logic exp_bit;
    logic mismatch;
    logic last_sample;
    logic wd_clear;
    logic wd_en;
    logic wd_expired;

    // Golden bit selected by a mask so the index width need not match EXPECTED.
    assign exp_bit     = |(EXPECTED & (NUM_SAMPLES'(1) << sample_index_q));
    // Case inequality so X/Z on result is always a mismatch.
    assign mismatch    = (result !== exp_bit);
    assign last_sample = (sample_index_q == CNT_W'(NUM_SAMPLES - 1));

    // Watchdog only runs in RUN; any valid sample or start rearms it.
    assign wd_clear = (state_q != RUN) || start || result_valid;
    assign wd_en    = (state_q == RUN);

    machine_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i      (clk),
        .rst_i      (rst),
        .clear_i    (wd_clear),
        .en_i       (wd_en),
        .expired_c_o(wd_expired)
    );

    // Run control FSM with registered counters and status.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            sample_index_q <= '0;
            error_count_q  <= '0;
            first_err_q    <= '1;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q        <= RUN;
                        sample_index_q <= '0;
                        error_count_q  <= '0;
                        first_err_q    <= '1;
                        done_q         <= 1'b0;
                        timeout_q      <= 1'b0;
                    end
                end
                RUN: begin
                    if (start) begin
                        // Restart wins over any sample presented this cycle.
                        sample_index_q <= '0;
                        error_count_q  <= '0;
                        first_err_q    <= '1;
                    end else if (result_valid) begin
                        sample_index_q <= sample_index_q + CNT_W'(1);
                        if (mismatch) begin
                            if (error_count_q != '1) begin
                                error_count_q <= error_count_q + CNT_W'(1);
                            end
                            if (error_count_q == '0) begin
                                first_err_q <= sample_index_q;
                            end
                        end
                        if (last_sample) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            timeout_q <= 1'b0;
                        end
                    end else if (wd_expired) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done            = done_q;
    assign timeout         = timeout_q;
    assign error_count     = error_count_q;
    assign sample_index    = sample_index_q;
    assign first_err_index = first_err_q;
    assign pass            = done_q & ~timeout_q & (error_count_q == '0);

endmodule
